// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//
// Plays a stored note sequence by driving the half-period input of the PWM
// buzzer. A host loads notes into an internal note RAM and pulses start; the
// block then steps through the RAM from address 0 up to last_addr. Each tone
// is held for its programmed number of duration ticks and is followed by a
// silent gap. Playback can be paused, stopped or looped.
//
// Note word: [15:14] octave shift, [13:10] note code (1..12 = C..B, other
//            codes are rests), [9:0] duration in ticks (0 = skip the note).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   wr_en      note RAM write strobe
//   wr_addr    note RAM write address
//   wr_data    note word to write
//   start      1-cycle pulse, begin playback at address 0 (ignored while busy)
//   stop       abort playback and return to IDLE (no done pulse)
//   pause      level, freezes playback timing while high
//   loop_en    sampled at end of sequence, 1 = restart at address 0
//   last_addr  address of the final note in the sequence
//   frequency  half-period count to the buzzer, 0 = silent
//   busy       high in any state except IDLE
//   paused     high while busy and pause is high
//   done       1-cycle pulse on natural end of sequence
//   cur_addr   address of the note being fetched or played
// ---------------------------------------------------------------------------
module melody_sequencer #(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 20,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [31:0]       frequency,
  output logic              busy,
  output logic              paused,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_next;
  logic [9:0]        dur;
  logic [9:0]        dur_next;
  logic [31:0]       tone;
  logic [31:0]       tone_next;
  logic              done_reg;
  logic              done_next;
  logic              note_end;
  logic              tick_wrap;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_data;

  // Fixed tone table on a 100 MHz basis; each octave step halves the period.
  function automatic logic [31:0] tone_lookup(input logic [15:0] word);
    logic [31:0] base;
    case (word[13:10])
      4'd1:    base = 32'd191109;
      4'd2:    base = 32'd180387;
      4'd3:    base = 32'd170264;
      4'd4:    base = 32'd160704;
      4'd5:    base = 32'd151684;
      4'd6:    base = 32'd143171;
      4'd7:    base = 32'd135138;
      4'd8:    base = 32'd127550;
      4'd9:    base = 32'd120394;
      4'd10:   base = 32'd113635;
      4'd11:   base = 32'd107258;
      4'd12:   base = 32'd101238;
      default: base = 32'd0;
    endcase
    return base >> word[15:14];
  endfunction

  // Note RAM. The read address is the address cur_addr takes at this edge,
  // so the word is already valid during the FETCH cycle that follows. A write
  // to the same address at the same edge leaves the old word on rd_data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[addr_next];
  end

  assign tick_wrap = (tick == TICK_W'(TICK_DIV - 1));

  // State register and control counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      tick     <= '0;
      dur      <= '0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      addr     <= addr_next;
      tick     <= tick_next;
      dur      <= dur_next;
      done_reg <= done_next;
    end
  end

  // Current tone is pure data; it is only visible while in PLAY.
  always_ff @(posedge clk) begin
    tone <= tone_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    addr_next  = addr;
    tick_next  = tick;
    dur_next   = dur;
    tone_next  = tone;
    done_next  = 1'b0;
    note_end   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          addr_next  = '0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        if (rd_data[9:0] == 10'd0) begin
          // Zero-length notes are skipped without a gap.
          note_end = 1'b1;
        end else begin
          tone_next  = tone_lookup(rd_data);
          dur_next   = rd_data[9:0];
          tick_next  = '0;
          state_next = PLAY;
        end
      end

      PLAY: begin
        if (!pause) begin
          if (tick_wrap) begin
            tick_next = '0;
            if (dur == 10'd1) begin
              if (GAP_TICKS == 0) begin
                note_end = 1'b1;
              end else begin
                // The duration counter is reused to time the gap.
                dur_next   = 10'(GAP_TICKS);
                state_next = GAP;
              end
            end else begin
              dur_next = dur - 1'b1;
            end
          end else begin
            tick_next = tick + 1'b1;
          end
        end
      end

      GAP: begin
        if (!pause) begin
          if (tick_wrap) begin
            tick_next = '0;
            if (dur == 10'd1) begin
              note_end = 1'b1;
            end else begin
              dur_next = dur - 1'b1;
            end
          end else begin
            tick_next = tick + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // End of a note: advance, wrap to the top when looping, or finish.
    if (note_end) begin
      if (addr != last_addr) begin
        addr_next  = addr + 1'b1;
        state_next = FETCH;
      end else if (loop_en) begin
        addr_next  = '0;
        state_next = FETCH;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end

    // Stop overrides everything, including a same-cycle start or pause.
    if (stop) begin
      state_next = IDLE;
      addr_next  = '0;
      done_next  = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    busy      = (state != IDLE);
    paused    = busy && pause;
    frequency = ((state == PLAY) && !pause) ? tone : 32'd0;
    done      = done_reg;
    cur_addr  = addr;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a stored note sequence by driving the 32-bit half-period `frequency` input of the PWM buzzer block.
- A host writes notes into an internal DEPTH-entry note RAM, then pulses `start`.
- The block steps through the RAM, holding each tone for its programmed duration, with a silent gap between notes.
- Supports pause, stop and loop.
- Sits between the top-level control FSM / keypad logic and the buzzer.

Parameters:
- TICK_DIV, 100000, clk cycles per duration tick (1 ms at 100 MHz)
- GAP_TICKS, 20, silent ticks inserted after each played note (0 = no gap)
- ADDR_W, 6, note RAM address width; DEPTH = 2**ADDR_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  note RAM write strobe
- wr_addr  in  ADDR_W  note RAM write address
- wr_data  in  16  note word: [15:14] octave shift, [13:10] note code, [9:0] duration in ticks
- start  in  1  1-cycle pulse; begin playback at address 0 (ignored while busy)
- stop  in  1  abort playback, return to IDLE
- pause  in  1  level; freezes playback while high
- loop_en  in  1  sampled at end of sequence; 1 = restart at address 0
- last_addr  in  ADDR_W  address of final note in sequence
- frequency  out  32  half-period count to buzzer; 0 = silent
- busy  out  1  high in any state except IDLE
- paused  out  1  high while busy and pause is high
- done  out  1  1-cycle pulse on natural end of sequence
- cur_addr  out  ADDR_W  address of note being fetched or played

Behaviour:
- Reset values (synchronous, highest priority): state = IDLE; frequency = 0; busy, paused, done = 0; cur_addr = 0; tick and duration counters = 0. Note RAM contents are not cleared.
- Note RAM:
  - Synchronous write on wr_en; writes are allowed at any time.
  - Synchronous read; data is valid the cycle after the address is presented.
  - Same-cycle read and write to the same address returns the old data.
- Tone lookup (fixed table, 100 MHz basis). Note codes 1..12 = C..B; base values:
  - C = 191109, C# = 180387, D = 170264, D# = 160704, E = 151684, F = 143171
  - F# = 135138, G = 127550, G# = 120394, A = 113635, A# = 107258, B = 101238
  - frequency = base >> octave.
  - Note codes 0 and 13..15 = rest (frequency 0 during the note's duration).
- FSM states: IDLE, FETCH, PLAY, GAP.
  - IDLE: frequency = 0. On start: cur_addr <= 0, go to FETCH; busy = 1 from the next cycle.
  - FETCH (1 cycle): present cur_addr to RAM; go to LOAD-equivalent handling on the next cycle, when the word is valid.
    - If duration == 0: skip the note with no gap; advance as in the end-of-note rule.
    - Else: frequency <= lookup, load the duration counter, clear the tick counter, go to PLAY.
  - PLAY: tick counter counts 0..TICK_DIV-1; each wrap decrements the duration counter. At the final wrap, frequency <= 0 and go to GAP (or apply the end-of-note rule directly if GAP_TICKS == 0). PLAY therefore lasts exactly duration*TICK_DIV cycles.
  - GAP: frequency = 0 for GAP_TICKS*TICK_DIV cycles, then apply the end-of-note rule.
- End-of-note rule:
  - cur_addr != last_addr: cur_addr + 1, go to FETCH.
  - Else if loop_en: cur_addr <= 0, go to FETCH.
  - Else: go to IDLE, pulse done for one cycle; busy drops in the same cycle done is high.
- Pause:
  - While pause = 1 in PLAY or GAP: tick and duration counters hold, frequency is forced to 0, paused = 1.
  - On release, the remaining time resumes exactly and the tone is restored.
  - Pause asserted in FETCH takes effect in the following PLAY/GAP.
  - Pause has no effect in IDLE.
- Stop: in any state, next cycle is IDLE with frequency = 0, busy = 0, cur_addr = 0, no done pulse. Stop has priority over start and pause in the same cycle.
- start while busy is ignored. start and stop in the same cycle from IDLE: remain IDLE.
- cur_addr wraps naturally at DEPTH-1 → 0 only through the loop path; last_addr bounds the sequence.

Test Plan (TICK_DIV=10, GAP_TICKS=2 unless stated):
1. Write addr0 = {2'd0, 4'd10, 10'd3} (A4, 3 ticks); last_addr = 0; pulse start → frequency = 113635 for exactly 30 cycles, then 0 for 20 cycles, then one-cycle done pulse; busy falls with done.
2. Write addr0 = {2'd1, 4'd1, 10'd2} and addr1 = {2'd0, 4'd0, 10'd1}; last_addr = 1 → 95554 for 20 cycles, gap, 0 for rest of 10 cycles, gap, done.
3. Set loop_en = 1 with scenario 1 contents → after the gap, cur_addr returns to 0 and frequency = 113635 again; no done pulse. Pulse stop mid-note → next cycle frequency = 0, busy = 0, no done.
4. Hold pause high for 37 cycles starting 12 cycles into a 3-tick note → frequency = 0 and paused = 1 for those cycles; the tone then resumes for the remaining 18 cycles; total PLAY time = 30 active cycles.
5. addr0 duration = 0, addr1 = C4 1 tick, last_addr = 1 → addr0 is skipped with no gap; 191109 appears 3 cycles after start.
6. Assert reset in PLAY → next cycle all outputs at reset values; RAM contents are preserved and a new start replays them. Write the same address being fetched → the old word is played.
